// File: rtl/npu_instr_sequencer.sv
// rtl/npu_instr_sequencer.sv - fetches NPU instructions from imem and issues them, draining after MV_MUL.
// Optional stall/wait cycle counter output is enabled by defining SEQ_PERF_CNT_EN.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 5
`endif
`ifndef MV_MUL
`define MV_MUL 2
`endif

module npu_instr_sequencer #(
  parameter int                      INSTR_WIDTH  = `INSTR_WIDTH,
  parameter int                      OPCODE_WIDTH = `OPCODE_WIDTH,
  parameter int                      IMEM_AWIDTH  = 8,
  parameter int                      MVM_LATENCY  = 12,
  parameter logic [OPCODE_WIDTH-1:0] END_OPCODE   = {OPCODE_WIDTH{1'b1}},
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR    = '0
) (
  input  logic                   clk,
  input  logic                   reset_npu_n,
  input  logic                   start,
  input  logic [IMEM_AWIDTH-1:0] start_pc,
  input  logic                   npu_stall,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  output logic                   imem_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            issued_count
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  localparam int CW = (MVM_LATENCY < 2) ? 1 : $clog2(MVM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, PRIME, ISSUE, WAIT, DRAIN} state_t;

  state_t                  state;
  logic [IMEM_AWIDTH-1:0]  pc;
  logic [CW-1:0]           wait_cnt;
  logic                    wrapped;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    is_end;
  logic                    is_mvm_wait;
  logic                    fetch;

  assign opcode      = imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign is_end      = (opcode == END_OPCODE);
  assign is_mvm_wait = (MVM_LATENCY > 0) && (opcode == OPCODE_WIDTH'(`MV_MUL));

  // pc always names the next word to read; imem_rdata holds the word at pc-1 while in ISSUE.
  // The read enable must drop in the same cycle as a stall so the memory output holds the pending word.
  assign fetch = (state == PRIME)
               || (state == ISSUE && !npu_stall && !is_end && !is_mvm_wait && !wrapped)
               || (state == WAIT && wait_cnt == CW'(1));

  assign imem_en   = fetch;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset_npu_n) begin
    if (!reset_npu_n) begin
      state        <= IDLE;
      pc           <= '0;
      wait_cnt     <= '0;
      wrapped      <= 1'b0;
      instruction  <= NOP_INSTR;
      instr_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      issued_count <= '0;
    end else begin
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      done        <= 1'b0;
      if (fetch) begin
        pc <= pc + IMEM_AWIDTH'(1);
        if (&pc) wrapped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            pc           <= start_pc;
            wrapped      <= 1'b0;
            busy         <= 1'b1;
            err          <= 1'b0;
            issued_count <= '0;
            state        <= PRIME;
          end
        end
        PRIME: state <= ISSUE;
        ISSUE: begin
          if (!npu_stall) begin
            if (is_end) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DRAIN;
            end else begin
              instruction <= imem_rdata;
              instr_valid <= 1'b1;
              if (issued_count != 16'hFFFF) issued_count <= issued_count + 16'd1;
              // The word at the top address was just issued; continuing would wrap.
              if (wrapped) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DRAIN;
              end else if (is_mvm_wait) begin
                wait_cnt <= CW'(MVM_LATENCY);
                state    <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) state <= ISSUE;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_npu_n) begin
    if (!reset_npu_n) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (((state == ISSUE && npu_stall) || state == WAIT) && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npu_instr_sequencer.sv
// tb/tb_npu_instr_sequencer.sv - scoreboard bench for npu_instr_sequencer with a program-level reference model.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 5
`endif
`ifndef MV_MUL
`define MV_MUL 2
`endif

module tb_npu_instr_sequencer;
  localparam int IW  = `INSTR_WIDTH;
  localparam int OW  = `OPCODE_WIDTH;
  localparam int AW  = 8;
  localparam int LAT = 12;
  localparam logic [OW-1:0] OP_END = {OW{1'b1}};
  localparam logic [OW-1:0] OP_MV  = OW'(`MV_MUL);
  localparam logic [OW-1:0] OP_VRD = OW'(1);
  localparam logic [OW-1:0] OP_VWR = OW'(3);
  localparam logic [OW-1:0] OP_MRD = OW'(4);

  logic          clk;
  logic          reset_npu_n;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          npu_stall;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   issued_count;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  npu_instr_sequencer #(
    .INSTR_WIDTH(IW), .OPCODE_WIDTH(OW), .IMEM_AWIDTH(AW), .MVM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_npu_n(reset_npu_n), .start(start), .start_pc(start_pc),
    .npu_stall(npu_stall), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
    .busy(busy), .done(done), .err(err), .issued_count(issued_count)
`ifdef SEQ_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] mem [0:255];
  initial imem_rdata = '0;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [IW-1:0] w; int t; } iss_t;
  typedef struct { int t; logic e; int n; int st; } dn_t;
  iss_t exp_q[$];
  dn_t  dn_q[$];
  bit   sched [0:1023];
  int   start_cyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instruction"}, instruction, '0);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_imem_en"}, imem_en, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_issued_count"}, issued_count, 0);
`ifdef SEQ_PERF_CNT_EN
    chk({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
  endtask

  function automatic logic [IW-1:0] mkword(input logic [OW-1:0] op);
    logic [IW-1:0] w;
    w = IW'({$urandom, $urandom});
    w[IW-1 -: OW] = op;
    return w;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 256; i++) mem[i] = mkword(OP_END);
    for (int i = 0; i < 1024; i++) sched[i] = 1'b0;
  endtask

  task automatic put(input int a, input logic [OW-1:0] op);
    mem[a % 256] = mkword(op);
  endtask

  // Program-level model: walk memory from start_pc, each word takes the next edge the NPU is not stalled.
  task automatic model(input int spc);
    int t, n, st, a;
    logic [IW-1:0] w;
    iss_t e;
    dn_t d;
    t = 2; n = 0; st = 0; a = spc;
    for (int k = 0; k < 257; k++) begin
      while (sched[t]) begin t++; st++; end
      w = mem[a];
      if (w[IW-1 -: OW] == OP_END) begin
        d.t = t; d.e = 1'b0; d.n = n; d.st = st; dn_q.push_back(d);
        break;
      end
      e.w = w; e.t = t; exp_q.push_back(e); n++;
      if (a == 255) begin
        d.t = t; d.e = 1'b1; d.n = n; d.st = st; dn_q.push_back(d);
        break;
      end
      if (w[IW-1 -: OW] == OP_MV) begin t += 1 + LAT; st += LAT; end
      else t += 1;
      a = (a + 1) % 256;
    end
  endtask

  always @(negedge clk) begin : monitor
    iss_t e;
    dn_t d;
    if (reset_npu_n === 1'b1) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: got %0h expected no issue (cycle %0d)", instruction, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("issue_word", instruction, e.w);
          chk("issue_time", cyc - start_cyc, e.t);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          d = dn_q.pop_front();
          chk("done_time", cyc - start_cyc, d.t);
          chk("done_err", err, d.e);
          chk("done_count", issued_count, d.n);
          chk("done_busy", busy, 0);
          chk("done_pending_issues", exp_q.size(), 0);
`ifdef SEQ_PERF_CNT_EN
          chk("done_stall_cycles", stall_cycles, d.st);
`endif
        end
      end
    end
  end

  task automatic run(input int spc, input int restart_at, input int reset_at);
    bit fin;
    fin = 1'b0;
    model(spc);
    @(negedge clk);
    start_pc = AW'(spc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    chk("start_busy", busy, 1);
    chk("start_err_clear", err, 0);
    for (int t = 1; t < 1000 && !fin; t++) begin
      npu_stall = sched[t];
      start = (t == restart_at);
      if (t == reset_at) begin
        #2 reset_npu_n = 1'b0;
        #1 chk_reset("async_reset");
        exp_q.delete();
        dn_q.delete();
        npu_stall = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_npu_n = 1'b1;
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (done) fin = 1'b1;
      end
    end
    npu_stall = 1'b0;
    start = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done expected done within 1000 cycles");
      exp_q.delete();
      dn_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [OW-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return OP_VRD;
      1: return OP_VWR;
      2: return OP_MRD;
      3: return OP_MV;
      default: return OW'($urandom_range(5, (1 << OW) - 2));
    endcase
  endfunction

  initial begin
    int spc, len;
    reset_npu_n = 1'b0;
    start = 1'b0;
    start_pc = '0;
    npu_stall = 1'b0;
    clear_all();
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) reset_npu_n = 1'b1;
    repeat (2) @(posedge clk);

    clear_all();
    put(0, OP_VRD); put(1, OP_VRD); put(2, OP_MRD); put(3, OP_END);
    run(0, -1, -1);

    clear_all();
    put(0, OP_MV); put(1, OP_VWR); put(2, OP_END);
    run(0, -1, -1);

    clear_all();
    for (int i = 0; i < 4; i++) put(i, OP_VRD);
    for (int t = 3; t <= 7; t++) sched[t] = 1'b1;
    run(0, -1, -1);

    clear_all();
    put(254, OP_VRD); put(255, OP_VRD);
    run(254, -1, -1);

    clear_all();
    put(0, OP_MV); put(1, OP_VWR); put(2, OP_END);
    run(0, -1, 6);

    clear_all();
    put(0, OP_VRD); put(1, OP_VRD); put(2, OP_MRD); put(3, OP_END);
    run(0, -1, -1);

    clear_all();
    put(64, OP_VRD); put(65, OP_VWR); put(66, OP_MRD); put(67, OP_VRD);
    run(64, 3, -1);

    for (int r = 0; r < 25; r++) begin
      clear_all();
      spc = $urandom_range(0, 255);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) put(spc + k, rand_op());
      for (int t = 0; t < 200; t++) sched[t] = ($urandom_range(0, 3) == 0);
      run(spc, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/npu_instr_sequencer.md
Name: npu_instr_sequencer

Overview:
- Fetches NPU instructions from an on-chip instruction memory and issues them to the NPU instruction port.
- Replaces the hand-timed instruction stream currently driven by the bench.
- Enforces a fixed post-issue wait after MV_MUL so dependent instructions never issue before the MVU/MFU pipeline drains.
- Runs from a start pulse until an END opcode is reached; reports busy, done and error.

Parameters:
- INSTR_WIDTH, `INSTR_WIDTH: instruction word width.
- OPCODE_WIDTH, `OPCODE_WIDTH: opcode field width, in instruction MSBs.
- IMEM_AWIDTH, 8: instruction memory address width.
- MVM_LATENCY, 12: idle cycles inserted after an MV_MUL issue (0 allowed).
- END_OPCODE, all-ones of OPCODE_WIDTH: opcode that terminates a program; never issued.
- NOP_INSTR, 0: word driven on instruction whenever instr_valid=0.

Ports:
- clk  in  1  clock.
- reset_npu_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin a program at start_pc.
- start_pc  in  IMEM_AWIDTH  first instruction address, sampled on start.
- npu_stall  in  1  NPU back-pressure; no issue or fetch advance while 1.
- imem_addr  out  IMEM_AWIDTH  instruction memory read address.
- imem_en  out  1  read enable; memory output holds when 0.
- imem_rdata  in  INSTR_WIDTH  read data, valid one cycle after imem_en=1.
- instruction  out  INSTR_WIDTH  to NPU.
- instr_valid  out  1  instruction holds a real issue this cycle.
- busy  out  1  program running.
- done  out  1  one-cycle pulse at program end.
- err  out  1  sticky: PC wrapped without END; cleared by next start.
- issued_count  out  16  instructions issued in current program, saturating.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - instruction=NOP_INSTR; instr_valid, busy, done, err, imem_en = 0.
  - imem_addr=0; issued_count=0; wait counter=0.
- States: IDLE, PRIME, ISSUE, WAIT, DRAIN.
- IDLE:
  - On start: pc<=start_pc, imem_addr<=start_pc, imem_en=1, busy=1, err=0, issued_count=0; go to PRIME.
  - start while busy is ignored.
- PRIME: one cycle covering read latency. Set pc<=pc+1 and imem_addr<=pc+1; go to ISSUE.
- ISSUE, each cycle, in priority order:
  - npu_stall=1: instr_valid=0, imem_en=0, pc frozen; rdata is held by the memory.
  - opcode(imem_rdata)==END_OPCODE: no issue; go to DRAIN.
  - Otherwise: instruction=imem_rdata, instr_valid=1, issued_count+1 (saturates at 16'hFFFF).
    - If opcode==`MV_MUL and MVM_LATENCY>0: load wait counter with MVM_LATENCY, imem_en=0, go to WAIT.
    - Else: imem_en=1, pc advances. Throughput is one instruction per cycle.
- WAIT:
  - Counter decrements each cycle; instr_valid=0; npu_stall is ignored.
  - At counter==1, assert imem_en with the already-advanced pc and return to ISSUE. Exactly MVM_LATENCY bubble cycles follow the MV_MUL.
- Wrap-around: if pc would increment from all-ones to 0 while running, set err=1 and go to DRAIN. The instruction at all-ones is still issued if it is not END.
- DRAIN: one cycle; done=1, busy=0, instr_valid=0; go to IDLE.
- Simultaneous events:
  - start in the same cycle as done is ignored.
  - npu_stall during PRIME has no effect.
- Reset mid-program aborts immediately to reset values; no done pulse.
- Opcode field is instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH]; other fields pass through unmodified.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined, adds output stall_cycles (16 bits, saturating):
  - counts cycles in ISSUE with npu_stall=1, plus all WAIT cycles;
  - cleared on start and on reset.
- When undefined: port and counter are absent; all other behaviour identical.

Test Plan:
- Program {V_RD a0, V_RD a1, M_RD a0, END} at pc 0, start_pc=0:
  - three issues on consecutive cycles, first issue 2 cycles after start;
  - then done pulse one cycle after END is seen; issued_count=3; err=0.
- Program {MV_MUL, V_WR, END}, MVM_LATENCY=12:
  - V_WR issues exactly 13 cycles after MV_MUL;
  - instr_valid=0 for the 12 cycles in between.
- npu_stall=1 for 5 cycles during a 4-V_RD sequence:
  - no instruction lost or duplicated; total issue span is 4+5 cycles;
  - with SEQ_PERF_CNT_EN, stall_cycles=5.
- start_pc=8'hFE, memory {V_RD, V_RD} with no END:
  - both issue, then err=1 and done pulse;
  - next start clears err.
- reset_npu_n pulled low in WAIT:
  - outputs return to reset values asynchronously, with no done pulse;
  - a fresh start then runs a program normally.
- Second start during a running program:
  - ignored; program completes unchanged with issued_count correct.
